// File: rtl/param_updown_counter_pkg.sv
// Shared constants for the parameterised up/down counter: mode and direction encodings.
package param_updown_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/param_updown_counter_sticky_flag.sv
// Set-dominant sticky flag with synchronous active-low reset and explicit clear.
module sticky_flag (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_set,
  input  logic i_clr,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else if (i_set) begin
      r_q <= 1'b1;
    end else if (i_clr) begin
      r_q <= 1'b0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/param_updown_counter.sv
// Loadable up/down counter with variable step, wrap or saturate bounds,
// registered terminal-count outputs and sticky overflow/underflow flags.
module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int          STEP_W  = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [WIDTH-1:0]  d,
  input  logic              load,
  input  logic              en,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic              sat_mode,
  input  logic              flag_clr,
  output logic [WIDTH-1:0]  qd,
  output logic              tc_max,
  output logic              tc_min,
  output logic              ovf,
  output logic              unf
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("param_updown_counter: WIDTH must be in 2..32");
  end
  if (STEP_W < 1 || STEP_W > WIDTH) begin : g_bad_step_w
    $error("param_updown_counter: STEP_W must be in 1..WIDTH");
  end
  if ({32'd0, RST_VAL} >= (64'd1 << WIDTH)) begin : g_bad_rst_val
    $error("param_updown_counter: RST_VAL does not fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] RST_Q    = RST_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] r_qd;
  logic             r_tc_max;
  logic             r_tc_min;

  logic [WIDTH:0]   w_step_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_next;
  logic             w_set_ovf;
  logic             w_set_unf;

  assign w_step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign w_sum      = {1'b0, r_qd} + w_step_ext;
  assign w_diff     = {1'b0, r_qd} - w_step_ext;

  // The extra MSB of sum/diff is the carry/borrow; it alone marks a bound crossing,
  // so landing exactly on a bound never raises a flag.
  always_comb begin
    w_next    = r_qd;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (load) begin
      w_next = d;
    end else if (en) begin
      if (up_down == DIR_UP) begin
        w_next    = (w_sum[WIDTH] && sat_mode == MODE_SAT) ? ALL_ONES : w_sum[WIDTH-1:0];
        w_set_ovf = w_sum[WIDTH];
      end else begin
        w_next    = (w_diff[WIDTH] && sat_mode == MODE_SAT) ? '0 : w_diff[WIDTH-1:0];
        w_set_unf = w_diff[WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      r_qd     <= RST_Q;
      r_tc_max <= (RST_Q == ALL_ONES);
      r_tc_min <= (RST_Q == '0);
    end else begin
      r_qd     <= w_next;
      r_tc_max <= &w_next;
      r_tc_min <= ~|w_next;
    end
  end

  sticky_flag u_ovf (
    .clk     (clk),
    .i_rst_n (clear),
    .i_set   (w_set_ovf),
    .i_clr   (flag_clr),
    .o_q     (ovf)
  );

  sticky_flag u_unf (
    .clk     (clk),
    .i_rst_n (clear),
    .i_set   (w_set_unf),
    .i_clr   (flag_clr),
    .o_q     (unf)
  );

  assign qd     = r_qd;
  assign tc_max = r_tc_max;
  assign tc_min = r_tc_min;

endmodule
